// File: rtl/mem_port_arbiter_pkg.sv
// Shared system definitions: data/tag widths, memory bus command and size
// encodings, and the memory-port arbiter state set.
package sys_defs;
    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 6;
    localparam int MEM_TAG_LEN = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_LD = 2'd1,
        ISSUE_ST = 2'd2,
        WAIT_LD  = 2'd3
    } MEM_ARB_STATE;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory bus between the arbiter (master) and the memory (slave).
interface mem_port_arbiter_if;
    import sys_defs::*;

    // Handshake: the master holds mem_command/addr/wdata/size until a cycle in
    // which mem_response is nonzero; that cycle is the transfer, and the
    // nonzero value is the transaction tag later echoed on mem_tag with mem_rdata.
    BUS_COMMAND             mem_command;
    logic [XLEN-1:0]        mem_addr;
    logic [XLEN-1:0]        mem_wdata;
    MEM_SIZE                mem_size;
    logic [MEM_TAG_LEN-1:0] mem_response;
    logic [MEM_TAG_LEN-1:0] mem_tag;
    logic [XLEN-1:0]        mem_rdata;

    modport master (
        output mem_command, mem_addr, mem_wdata, mem_size,
        input  mem_response, mem_tag, mem_rdata
    );

    modport slave (
        input  mem_command, mem_addr, mem_wdata, mem_size,
        output mem_response, mem_tag, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by the load buffer (one-entry slot) and ROB store commit.
// Optional MEM_ARB_RR_EN: alternate load/store on conflicts instead of fixed store priority.
module mem_port_arbiter
    import sys_defs::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_ld_req,
    input  logic [XLEN-1:0]        i_ld_addr,
    input  logic [ROB_TAG_LEN-1:0] i_ld_rob_tag,
    input  logic                   i_st_req,
    input  logic [XLEN-1:0]        i_st_addr,
    input  logic [XLEN-1:0]        i_st_data,
    input  MEM_SIZE                i_st_size,
    output logic                   o_mem_busy,
    output logic                   o_st_ack,
    output logic                   o_ld_done,
    output logic [ROB_TAG_LEN-1:0] o_ld_done_tag,
    output logic [XLEN-1:0]        o_ld_done_data,
    output MEM_ARB_STATE           o_state,
    mem_port_arbiter_if.master     mem
);

    MEM_ARB_STATE           r_state;
    MEM_ARB_STATE           w_next_state;
    logic                   r_slot_valid;
    logic [XLEN-1:0]        r_slot_addr;
    logic [ROB_TAG_LEN-1:0] r_slot_tag;
    logic [MEM_TAG_LEN-1:0] r_mem_tag;
    logic [ROB_TAG_LEN-1:0] r_inflight_tag;
    logic                   r_st_ack;
    logic                   r_ld_done;
    logic [ROB_TAG_LEN-1:0] r_ld_done_tag;
    logic [XLEN-1:0]        r_ld_done_data;

    logic                   w_ld_pending;
    logic                   w_st_pending;
    logic                   w_ld_wins;
    logic                   w_accept;
    logic                   w_ld_accept;
    logic                   w_st_accept;
    logic                   w_ld_hit;
    BUS_COMMAND             w_cmd;
    logic [XLEN-1:0]        w_addr;
    logic [XLEN-1:0]        w_wdata;
    MEM_SIZE                w_size;

    assign w_ld_pending = r_slot_valid | i_ld_req;
    // The store being acked this cycle is still requested; it must not be re-issued.
    assign w_st_pending = i_st_req & ~r_st_ack;
    assign w_accept     = (mem.mem_response != '0);
    assign w_ld_accept  = (r_state == ISSUE_LD) && w_accept;
    assign w_st_accept  = (r_state == ISSUE_ST) && w_accept;
    assign w_ld_hit     = (r_state == WAIT_LD) && (r_mem_tag != '0) && (mem.mem_tag == r_mem_tag);

`ifdef MEM_ARB_RR_EN
    logic r_last_grant_ld;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant_ld <= 1'b0;
        end else if (r_state == IDLE && w_next_state == ISSUE_LD) begin
            r_last_grant_ld <= 1'b1;
        end else if (r_state == IDLE && w_next_state == ISSUE_ST) begin
            r_last_grant_ld <= 1'b0;
        end
    end

    assign w_ld_wins = w_ld_pending & (~w_st_pending | ~r_last_grant_ld);
`else
    assign w_ld_wins = w_ld_pending & ~w_st_pending;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd        = BUS_NONE;
        w_addr       = '0;
        w_wdata      = '0;
        w_size       = BYTE;
        case (r_state)
            IDLE: begin
                if (w_ld_wins) begin
                    w_next_state = ISSUE_LD;
                end else if (w_st_pending) begin
                    w_next_state = ISSUE_ST;
                end
            end
            ISSUE_LD: begin
                w_cmd  = BUS_LOAD;
                w_addr = r_slot_addr;
                w_size = WORD;
                if (w_accept) begin
                    w_next_state = WAIT_LD;
                end
            end
            ISSUE_ST: begin
                w_cmd   = BUS_STORE;
                w_addr  = i_st_addr;
                w_wdata = i_st_data;
                w_size  = i_st_size;
                if (w_accept) begin
                    w_next_state = IDLE;
                end
            end
            WAIT_LD: begin
                if (w_ld_hit) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The ROB tag moves out of the slot at acceptance so a load arriving
    // during WAIT_LD can refill the slot without corrupting the completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_slot_valid   <= 1'b0;
            r_slot_addr    <= '0;
            r_slot_tag     <= '0;
            r_mem_tag      <= '0;
            r_inflight_tag <= '0;
            r_st_ack       <= 1'b0;
            r_ld_done      <= 1'b0;
            r_ld_done_tag  <= '0;
            r_ld_done_data <= '0;
        end else begin
            r_st_ack  <= w_st_accept;
            r_ld_done <= w_ld_hit;
            if (i_ld_req) begin
                r_slot_valid <= 1'b1;
                r_slot_addr  <= i_ld_addr;
                r_slot_tag   <= i_ld_rob_tag;
            end else if (w_ld_accept) begin
                r_slot_valid <= 1'b0;
            end
            if (w_ld_accept) begin
                r_mem_tag      <= mem.mem_response;
                r_inflight_tag <= r_slot_tag;
            end else if (w_ld_hit) begin
                r_mem_tag <= '0;
            end
            if (w_ld_hit) begin
                r_ld_done_tag  <= r_inflight_tag;
                r_ld_done_data <= mem.mem_rdata;
            end
        end
    end

    assign o_mem_busy       = r_slot_valid | i_ld_req | (r_state != IDLE);
    assign o_st_ack         = r_st_ack;
    assign o_ld_done        = r_ld_done;
    assign o_ld_done_tag    = r_ld_done_tag;
    assign o_ld_done_data   = r_ld_done_data;
    assign o_state          = r_state;
    assign mem.mem_command  = w_cmd;
    assign mem.mem_addr     = w_addr;
    assign mem.mem_wdata    = w_wdata;
    assign mem.mem_size     = w_size;

endmodule
